// File: rtl/dcache_miss_controller.sv
// dcache_miss_controller
//   Sequencing FSM for the direct-mapped, write-through, no-write-allocate
//   data cache in the MEM stage. Stalls the pipeline on a load miss or a
//   store, refills a missing line word by word from main memory, drives the
//   data/tag array write enables and keeps saturating load hit/miss counters.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   mem_read    load in MEM stage
//   mem_write   store in MEM stage
//   hit         tag match and valid for the current address
//   mem_ready   main-memory completion strobe for the current word
//   stall       freeze PC and pipeline registers
//   mem_rd_req  main-memory read request (level-held)
//   mem_wr_req  main-memory write request (write-through, level-held)
//   word_idx    word offset for the fill read and the data-array write
//   fill_we     write the memory word into the data array at word_idx
//   store_we    write pipeline store data into the data array (store hit)
//   tag_we      write tag and set valid for the current index
//   hit_count   load hits, saturating
//   miss_count  load misses, saturating

module dcache_miss_controller #(
   parameter int BLOCK_WORDS = 4,
   parameter int WORD_BITS   = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 hit,
   input  logic                 mem_ready,
   output logic                 stall,
   output logic                 mem_rd_req,
   output logic                 mem_wr_req,
   output logic [WORD_BITS-1:0] word_idx,
   output logic                 fill_we,
   output logic                 store_we,
   output logic                 tag_we,
   output logic [CNT_W-1:0]     hit_count,
   output logic [CNT_W-1:0]     miss_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      UPDATE = 2'd2,
      WRITE  = 2'd3
   } state_t;

   localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(BLOCK_WORDS - 1);
   localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

   state_t               state;
   state_t               next_state;
   logic [WORD_BITS-1:0] counter;
   logic [WORD_BITS-1:0] counter_next;
   logic                 replay;
   logic                 replay_next;
   logic                 hit_inc;
   logic                 miss_inc;

   // State, word counter and replay flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         counter <= {WORD_BITS{1'b0}};
         replay  <= 1'b0;
      end else begin
         state   <= next_state;
         counter <= counter_next;
         replay  <= replay_next;
      end
   end

   // Saturating load hit/miss statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= {CNT_W{1'b0}};
         miss_count <= {CNT_W{1'b0}};
      end else begin
         if (hit_inc && (hit_count != CNT_MAX)) begin
            hit_count <= hit_count + CNT_W'(1);
         end
         if (miss_inc && (miss_count != CNT_MAX)) begin
            miss_count <= miss_count + CNT_W'(1);
         end
      end
   end

   // Next-state and output decode. Everything is forced low while rst is
   // asserted so no request or array write can leak out during reset, even
   // though stall/store_we/fill_we are combinational on the inputs.
   always_comb begin
      next_state   = state;
      counter_next = counter;
      replay_next  = replay;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      stall        = 1'b0;
      mem_rd_req   = 1'b0;
      mem_wr_req   = 1'b0;
      word_idx     = {WORD_BITS{1'b0}};
      fill_we      = 1'b0;
      store_we     = 1'b0;
      tag_we       = 1'b0;

      if (!rst) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               // A load wins over a store if the decoder ever raises both.
               if (mem_read) begin
                  if (hit) begin
                     // The first hit after a refill is the replayed miss
                     // and must not be counted a second time.
                     hit_inc     = ~replay;
                     replay_next = 1'b0;
                  end else begin
                     stall        = 1'b1;
                     miss_inc     = 1'b1;
                     counter_next = {WORD_BITS{1'b0}};
                     next_state   = FILL;
                  end
               end else if (mem_write) begin
                  stall      = 1'b1;
                  store_we   = hit;
                  next_state = WRITE;
               end else begin
                  next_state = IDLE;
               end
            end

            FILL: begin
               stall      = 1'b1;
               mem_rd_req = 1'b1;
               word_idx   = counter;
               if (mem_ready) begin
                  fill_we      = 1'b1;
                  counter_next = counter + WORD_BITS'(1);
                  if (counter == LAST_WORD) begin
                     next_state = UPDATE;
                  end else begin
                     next_state = FILL;
                  end
               end else begin
                  next_state = FILL;
               end
            end

            UPDATE: begin
               stall       = 1'b1;
               tag_we      = 1'b1;
               replay_next = 1'b1;
               next_state  = IDLE;
            end

            WRITE: begin
               // Releasing stall in the completion cycle lets the store
               // retire without an extra bubble.
               mem_wr_req = 1'b1;
               stall      = ~mem_ready;
               if (mem_ready) begin
                  next_state = IDLE;
               end else begin
                  next_state = WRITE;
               end
            end

            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dcache_miss_controller.md
Name: dcache_miss_controller

Overview:
- Sequencing FSM for the direct-mapped data cache in the MEM stage of the MIPS pipeline.
- Watches the decoded load/store strobes and the cache tag-compare result, stalls the pipeline on a load miss or a store, and fills the missing line word-by-word from main memory.
- Drives the data-array and tag-array write enables. Write policy: write-through, no write-allocate.
- Keeps saturating hit/miss statistics counters.

Parameters:
- BLOCK_WORDS, 4, words per cache line; power of two, ≥2.
- WORD_BITS, 2, log2(BLOCK_WORDS); width of word_idx.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read  input  1  load in MEM stage (from decoder `load`).
- mem_write  input  1  store in MEM stage (from decoder `WMEM`).
- hit  input  1  tag match AND valid for the current address.
- mem_ready  input  1  main-memory completion strobe for the current word read or write.
- stall  output  1  freeze PC and the IF/ID/EX/MEM pipeline registers.
- mem_rd_req  output  1  main-memory read request.
- mem_wr_req  output  1  main-memory write request (write-through).
- word_idx  output  WORD_BITS  word offset used for the fill read and the data-array write.
- fill_we  output  1  write the memory word into the data array at word_idx.
- store_we  output  1  write the pipeline store data into the data array (store hit).
- tag_we  output  1  write tag and set valid for the current index.
- hit_count  output  CNT_W  load hits, saturating.
- miss_count  output  CNT_W  load misses, saturating.

Behaviour:
- States: IDLE, FILL, UPDATE, WRITE. State, word counter, replay flag and both stat counters are registers.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter, replay, hit_count and miss_count go to 0.
  - All outputs are 0 during reset.
  - Reset mid-FILL abandons the line. tag_we never fired, so the partially written line stays invalid.
- IDLE:
  - mem_read & hit: stall=0. hit_count increments unless replay=1; in either case replay clears.
  - mem_read & !hit: stall=1 in the same cycle (combinational). miss_count increments, counter clears, next state FILL.
  - mem_write with mem_read=0: stall=1 in the same cycle; store_we=hit for this one cycle only; next state WRITE.
  - mem_read & mem_write together is illegal from the decoder; the load takes priority.
  - No request: all outputs 0.
- FILL:
  - stall=1, mem_rd_req=1, word_idx=counter.
  - On mem_ready: fill_we=1 in the same cycle and counter increments.
  - On mem_ready with counter==BLOCK_WORDS-1: counter wraps to 0 and next state is UPDATE.
  - Without mem_ready, the state holds and mem_rd_req stays high; requests are level-held.
- UPDATE: exactly 1 cycle. stall=1, tag_we=1, replay set; next state IDLE.
  - The replayed load then hits in IDLE with stall=0 and is not counted as a hit.
- WRITE:
  - mem_wr_req=1 and stall=!mem_ready.
  - On mem_ready, stall=0 that same cycle so the store retires; next state IDLE.
  - No data-array or tag writes occur in this state.
- Outputs are Moore, except stall/store_we in IDLE and fill_we/stall in FILL/WRITE, which are combinational on inputs as stated above.
- Counters hold at 2^CNT_W-1.
- Miss penalty with mem_ready tied high: BLOCK_WORDS+2 stall cycles (miss cycle + BLOCK_WORDS fill cycles + UPDATE).

Test Plan:
- Reset, then load with hit=1 for 3 cycles → stall=0 throughout, hit_count=3, miss_count=0.
- Load miss, mem_ready=1 every cycle, BLOCK_WORDS=4:
  - stall high for 6 cycles.
  - fill_we pulses with word_idx 0,1,2,3, then tag_we for 1 cycle.
  - Replay with hit=1 gives stall=0; miss_count=1, hit_count=0.
- Load miss, mem_ready only every 3rd cycle → mem_rd_req held high, word_idx steps only on mem_ready, total stall = 1+12+1 = 14 cycles.
- Store with hit=1, mem_ready after 2 cycles → store_we 1 cycle, mem_wr_req 3 cycles, stall 1,1,1,0, stat counters unchanged.
- Store with hit=0 → store_we=0, mem_wr_req asserted, stall released on mem_ready; tag_we and fill_we stay 0.
- Assert rst=0 after the second fill word → immediate IDLE with all outputs 0 and no tag_we. A reissued load with hit=0 restarts at word_idx=0 and miss_count increments again.
